intr_source_ctrl: RTL

- Interrupt requester at the device side of the CPU's intr/intr_ack handshake.
- Collects up to N_IRQ peripheral interrupt lines and latches their rising edges as pending.
- Applies a programmable mask and fixed priority, then drives the single intr line into the control unit.
- Exposes mask, pending, vector and status registers on the IO bus (cs/wr/rd), so the ISR can identify and clear the source.

---
 rtl/intr_source_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/intr_source_ctrl.sv
// Device-side interrupt requester: edge-latched pending bits, mask, fixed
// lowest-index priority and the intr/intr_ack handshake, with an IO register window.
module intr_source_ctrl #(
  parameter int unsigned N_IRQ    = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  output logic             intr,
  input  logic             intr_ack,
  input  logic             io_cs,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [1:0]       io_addr,
  input  logic [31:0]      io_din,
  output logic [31:0]      io_dout,
  output logic             in_service
);

  localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [ID_W-1:0]  vec_id_q, vec_id_d;
  logic             intr_q, intr_d;
  logic             in_service_q, in_service_d;
  logic [31:0]      io_dout_q, io_dout_d;

  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] w1c;
  logic [ID_W-1:0]  win_id;
  logic             wr_en, rd_en;
  logic             unused_din;

  assign unused_din = ^io_din[31:N_IRQ];

  assign active = pending_q & mask_q;
  assign wr_en  = io_cs & io_wr;
  assign rd_en  = io_cs & io_rd;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_id = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      pending_q    <= '0;
      irq_prev_q   <= '0;
      vec_id_q     <= '0;
      intr_q       <= 1'b0;
      in_service_q <= 1'b0;
      io_dout_q    <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      irq_prev_q   <= irq;
      vec_id_q     <= vec_id_d;
      intr_q       <= intr_d;
      in_service_q <= in_service_d;
      io_dout_q    <= io_dout_d;
    end
  end

  // Next-state; vec_id is frozen once the request leaves IDLE.
  always_comb begin
    state_d  = state_q;
    vec_id_d = vec_id_q;
    ack_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|active) begin
          state_d  = ST_REQ;
          vec_id_d = win_id;
        end
      end
      ST_REQ: begin
        if (intr_ack) begin
          state_d = ST_WAIT;
          ack_clr = N_IRQ'(1) << vec_id_q;
        end
      end
      ST_WAIT: begin
        if (!intr_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    intr_d       = 1'b0;
    in_service_d = 1'b0;
    intr_d       = (state_d == ST_REQ);
    in_service_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
  end

  // Register window; a new edge overrides any clear on the same bit.
  always_comb begin
    w1c       = (wr_en && io_addr == 2'd1) ? io_din[N_IRQ-1:0] : '0;
    pending_d = (pending_q & ~(ack_clr | w1c)) | (irq & ~irq_prev_q);
    mask_d    = (wr_en && io_addr == 2'd0) ? io_din[N_IRQ-1:0] : mask_q;
    io_dout_d = io_dout_q;
    if (rd_en) begin
      case (io_addr)
        2'd0:    io_dout_d = 32'(mask_q);
        2'd1:    io_dout_d = 32'(pending_q);
        2'd2:    io_dout_d = VEC_BASE + 32'({vec_id_q, 2'b00});
        default: io_dout_d = {28'b0, intr_q, in_service_q, state_q};
      endcase
    end
  end

  assign intr       = intr_q;
  assign in_service = in_service_q;
  assign io_dout    = io_dout_q;

endmodule
